// File: rtl/seq_ctrl_pkg.sv
// Shared types and defaults for the sequence controller that steps
// X-load, ALU compute, writeback drain and SRAM result read-back.
package seq_ctrl_pkg;

  localparam int unsigned DEF_N_RES     = 16;
  localparam int unsigned DEF_TMO       = 255;
  localparam int unsigned DEF_DRAIN_CYC = 2;
  localparam int unsigned ADDR_W        = 8;
  localparam int unsigned CNT_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_READ    = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

endpackage

// File: rtl/seq_ctrl_tmo_cnt.sv
// Loadable up-counter with clear, enable and terminal-count flag; shared by
// the timeout and drain phases of the sequence controller.
module seq_ctrl_tmo_cnt
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_tc_val,
  output logic         o_tc_c
);

  logic [W-1:0] r_cnt;

  // Clear beats load beats count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc_c = (r_cnt == i_tc_val);

endmodule

// File: rtl/seq_ctrl.sv
// Job sequencer: LOAD -> COMPUTE -> DRAIN -> READ -> DONE with per-phase
// timeout into ERR and abort back to IDLE. Owns no datapath registers.
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned N_RES     = DEF_N_RES,
  parameter int unsigned TMO       = DEF_TMO,
  parameter int unsigned DRAIN_CYC = DEF_DRAIN_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              xload_done,
  input  logic              ALU_done,
  input  logic              ry,
  output logic              input_load_en,
  output logic              ALU_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_RES - 1);
  localparam logic [CNT_W-1:0]  TMO_TC    = CNT_W'(TMO - 1);
  localparam logic [CNT_W-1:0]  DRAIN_TC  = CNT_W'(DRAIN_CYC - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_tc;
  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic [CNT_W-1:0]  w_tc_val;
  logic              r_input_load_en;
  logic              r_alu_en;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  // Counter restarts on every state entry; only the waiting phases advance it.
  assign w_cnt_clr = (w_state_nxt != r_state);
  assign w_cnt_en  = (r_state == ST_LOAD) || (r_state == ST_COMPUTE) || (r_state == ST_DRAIN);
  assign w_tc_val  = (r_state == ST_DRAIN) ? DRAIN_TC : TMO_TC;

  seq_ctrl_tmo_cnt #(
    .W (CNT_W)
  ) u_tmo_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .i_clr      (w_cnt_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_cnt_en),
    .i_tc_val   (w_tc_val),
    .o_tc_c     (w_tc)
  );

  // Next state; completion inputs win over a coincident timeout, abort wins over all.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (xload_done)  w_state_nxt = ST_COMPUTE;
        else if (w_tc)   w_state_nxt = ST_ERR;
      end
      ST_COMPUTE: begin
        if (ALU_done)    w_state_nxt = ST_DRAIN;
        else if (w_tc)   w_state_nxt = ST_ERR;
      end
      ST_DRAIN:   if (w_tc) w_state_nxt = ST_READ;
      ST_READ:    if (ry && (r_rd_addr == LAST_ADDR)) w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      ST_ERR:     w_state_nxt = ST_ERR;
      default:    w_state_nxt = ST_IDLE;
    endcase
    if (abort) w_state_nxt = ST_IDLE;
  end

  // State plus outputs decoded from the next state so every output is a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_input_load_en <= 1'b0;
      r_alu_en        <= 1'b0;
      r_rd_en         <= 1'b0;
      r_rd_addr       <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_input_load_en <= (w_state_nxt == ST_LOAD);
      r_alu_en        <= (w_state_nxt == ST_COMPUTE);
      r_rd_en         <= (w_state_nxt == ST_READ);
      r_busy          <= (w_state_nxt != ST_IDLE);
      r_done          <= (w_state_nxt == ST_DONE);
      r_err           <= (w_state_nxt == ST_ERR);
      // Staying in READ after an accepted read implies not last, so no wrap.
      if (w_state_nxt != ST_READ) begin
        r_rd_addr <= '0;
      end else if ((r_state == ST_READ) && ry) begin
        r_rd_addr <= r_rd_addr + ADDR_W'(1);
      end
    end
  end

  assign input_load_en = r_input_load_en;
  assign ALU_en        = r_alu_en;
  assign rd_en         = r_rd_en;
  assign rd_addr       = r_rd_addr;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule
